imem_load_ctrl: RTL



---
 rtl/imem_load_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Program-load controller and single-port arbiter for the instruction memory.
// Packs a host byte stream into little-endian words and stalls the core while loading.
module imem_load_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                start_idle;
    logic                unused_fetch_hi;

    assign accept     = (state_q == LOAD) && byte_valid && byte_ready_q;
    assign start_idle = (state_q == IDLE) && start;

    // Only the word index reaches the memory; upper fetch bits wrap.
    assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && (word_count != '0)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && (idx_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = (rem_q == ONE_C) ? DONE : LOAD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        if (start_idle) begin
            ptr_d = '0;
            idx_d = '0;
            if (word_count > DEPTH_C) begin
                rem_d = DEPTH_C;
                err_d = 1'b1;
            end else begin
                rem_d = word_count;
                err_d = 1'b0;
            end
        end

        if (accept) begin
            unique case (idx_q)
                2'd0: wdata_d[7:0]   = byte_data;
                2'd1: wdata_d[15:8]  = byte_data;
                2'd2: wdata_d[23:16] = byte_data;
                2'd3: wdata_d[31:24] = byte_data;
                default: wdata_d = wdata_q;
            endcase
            idx_d = idx_q + 2'd1;
        end

        if (state_q == WRITE) begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - ONE_C;
        end

        // Strobes are registered from the next state so they align with it.
        byte_ready_d = (state_d == LOAD);
        mem_we_d     = (state_d == WRITE);
        busy_d       = (state_d != IDLE);
        cpu_hold_d   = (state_d != IDLE);
        done_d       = (state_d == DONE)
                     || (start_idle && (word_count == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            rem_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mem_addr   = busy_q ? ptr_q : fetch_addr[ADDR_W-1:0];
    assign mem_wdata  = wdata_q;
    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
